mips_cpu_bus: RTL and testbench

MIPS_CPU_BUS -- requirements
Module: mips_cpu_bus

---
 rtl/mips_pkg.sv | 74 +++++++
 rtl/mips_cpu_regfile.sv | 31 +++
 rtl/mips_cpu_bus.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_mips_cpu_bus.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings and FSM state type for the bus-attached MIPS core.
package mips_pkg;

    // state    | meaning
    // ST_FETCH | instruction read on the bus at PC, held while waitrequest
    // ST_EXEC  | readdata holds the instruction; decode, ALU, branch, HI/LO
    // ST_MEM   | load/store request on the bus, held while waitrequest
    // ST_WB    | readdata holds load data; extract lanes into rt
    // ST_HALT  | jumped to address 0; bus idle until reset
    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_MEM   = 3'd2,
        ST_WB    = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_cpu_regfile.sv
// 32x32 general-purpose register file: two async read ports, one sync write port.
// $0 is hard-wired to zero; $2 is exported for observation.
module mips_cpu_regfile (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  raddr_a_i,
    output logic [31:0] rdata_a_o,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_b_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] v0_o
);

    logic [31:0] regs_q [32];

    // Register storage; writes aimed at $0 are dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : regs_q[raddr_b_i];
    assign v0_o      = regs_q[2];

endmodule

// File: rtl/mips_cpu_bus.sv
// Multi-cycle, non-pipelined MIPS-I subset core with a single shared
// read/write memory bus (waitrequest handshake, one-cycle read latency).
// The instruction is decoded straight from readdata in ST_EXEC, so nothing
// but the load/store context needs latching between states.
module mips_cpu_bus
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, npc_q, npc_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] ea_q, ea_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        mem_store_q, mem_store_d;
    logic [5:0]  ld_op_q, ld_op_d;
    logic [4:0]  ld_rt_q, ld_rt_d;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_s, imm_z, rs_val, rt_val, pc_plus4;
    logic [63:0] prod_s, prod_u;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;

    logic        ex_we, ex_take, ex_load, ex_store;
    logic [4:0]  ex_wa;
    logic [31:0] ex_wd, ex_target, ex_hi, ex_lo, ex_ea, ex_wdata;
    logic [3:0]  ex_be;

    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    assign op       = readdata[31:26];
    assign rs       = readdata[25:21];
    assign rt       = readdata[20:16];
    assign rd       = readdata[15:11];
    assign shamt    = readdata[10:6];
    assign funct    = readdata[5:0];
    assign imm_s    = sext16(readdata[15:0]);
    assign imm_z    = {16'd0, readdata[15:0]};
    assign pc_plus4 = pc_q + 32'd4;

    mips_cpu_regfile u_regfile (
        .clk_i     (clk),
        .rst_i     (reset),
        .raddr_a_i (rs),
        .rdata_a_o (rs_val),
        .raddr_b_i (rt),
        .rdata_b_o (rt_val),
        .we_i      (rf_we),
        .waddr_i   (rf_wa),
        .wdata_i   (rf_wd),
        .v0_o      (register_v0)
    );

    // Sign-extending both operands to 64 bits makes the low 64 bits of an
    // unsigned product equal to the signed product.
    assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};
    assign quot_s = $signed(rs_val) / $signed(rt_val);
    assign rem_s  = $signed(rs_val) % $signed(rt_val);
    assign quot_u = rs_val / rt_val;
    assign rem_u  = rs_val % rt_val;

    // Decode and execute the instruction currently presented on readdata.
    always_comb begin
        ex_we     = 1'b0;
        ex_wa     = rd;
        ex_wd     = 32'd0;
        ex_take   = 1'b0;
        ex_target = pc_plus4 + {imm_s[29:0], 2'b00};
        ex_hi     = hi_q;
        ex_lo     = lo_q;
        ex_load   = 1'b0;
        ex_store  = 1'b0;
        ex_ea     = rs_val + imm_s;
        ex_wdata  = rt_val;
        ex_be     = 4'b1111;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    FN_SLL:   begin ex_we = 1'b1; ex_wd = rt_val << shamt; end
                    FN_SRL:   begin ex_we = 1'b1; ex_wd = rt_val >> shamt; end
                    FN_SRA:   begin ex_we = 1'b1; ex_wd = $signed(rt_val) >>> shamt; end
                    FN_SLLV:  begin ex_we = 1'b1; ex_wd = rt_val << rs_val[4:0]; end
                    FN_SRLV:  begin ex_we = 1'b1; ex_wd = rt_val >> rs_val[4:0]; end
                    FN_SRAV:  begin ex_we = 1'b1; ex_wd = $signed(rt_val) >>> rs_val[4:0]; end
                    FN_JR:    begin ex_take = 1'b1; ex_target = rs_val; end
                    FN_JALR:  begin
                        ex_take = 1'b1; ex_target = rs_val;
                        ex_we = 1'b1; ex_wd = pc_q + 32'd8;
                    end
                    FN_MFHI:  begin ex_we = 1'b1; ex_wd = hi_q; end
                    FN_MFLO:  begin ex_we = 1'b1; ex_wd = lo_q; end
                    FN_MTHI:  ex_hi = rs_val;
                    FN_MTLO:  ex_lo = rs_val;
                    FN_MULT:  {ex_hi, ex_lo} = prod_s;
                    FN_MULTU: {ex_hi, ex_lo} = prod_u;
                    FN_DIV:   if (rt_val != 32'd0) begin ex_lo = quot_s; ex_hi = rem_s; end
                    FN_DIVU:  if (rt_val != 32'd0) begin ex_lo = quot_u; ex_hi = rem_u; end
                    FN_ADDU:  begin ex_we = 1'b1; ex_wd = rs_val + rt_val; end
                    FN_SUBU:  begin ex_we = 1'b1; ex_wd = rs_val - rt_val; end
                    FN_AND:   begin ex_we = 1'b1; ex_wd = rs_val & rt_val; end
                    FN_OR:    begin ex_we = 1'b1; ex_wd = rs_val | rt_val; end
                    FN_XOR:   begin ex_we = 1'b1; ex_wd = rs_val ^ rt_val; end
                    FN_NOR:   begin ex_we = 1'b1; ex_wd = ~(rs_val | rt_val); end
                    FN_SLT:   begin ex_we = 1'b1; ex_wd = {31'd0, $signed(rs_val) < $signed(rt_val)}; end
                    FN_SLTU:  begin ex_we = 1'b1; ex_wd = {31'd0, rs_val < rt_val}; end
                    default:  ;
                endcase
            end
            OP_REGIMM: begin
                if (rt == RT_BLTZ)      ex_take = rs_val[31];
                else if (rt == RT_BGEZ) ex_take = ~rs_val[31];
            end
            OP_J:     begin ex_take = 1'b1; ex_target = {pc_plus4[31:28], readdata[25:0], 2'b00}; end
            OP_JAL:   begin
                ex_take = 1'b1; ex_target = {pc_plus4[31:28], readdata[25:0], 2'b00};
                ex_we = 1'b1; ex_wa = 5'd31; ex_wd = pc_q + 32'd8;
            end
            OP_BEQ:   ex_take = (rs_val == rt_val);
            OP_BNE:   ex_take = (rs_val != rt_val);
            OP_BLEZ:  ex_take = rs_val[31] || (rs_val == 32'd0);
            OP_BGTZ:  ex_take = !rs_val[31] && (rs_val != 32'd0);
            OP_ADDIU: begin ex_we = 1'b1; ex_wa = rt; ex_wd = rs_val + imm_s; end
            OP_SLTI:  begin ex_we = 1'b1; ex_wa = rt; ex_wd = {31'd0, $signed(rs_val) < $signed(imm_s)}; end
            OP_SLTIU: begin ex_we = 1'b1; ex_wa = rt; ex_wd = {31'd0, rs_val < imm_s}; end
            OP_ANDI:  begin ex_we = 1'b1; ex_wa = rt; ex_wd = rs_val & imm_z; end
            OP_ORI:   begin ex_we = 1'b1; ex_wa = rt; ex_wd = rs_val | imm_z; end
            OP_XORI:  begin ex_we = 1'b1; ex_wa = rt; ex_wd = rs_val ^ imm_z; end
            OP_LUI:   begin ex_we = 1'b1; ex_wa = rt; ex_wd = {readdata[15:0], 16'd0}; end
            OP_LB, OP_LBU: begin ex_load = 1'b1; ex_be = 4'b0001 << ex_ea[1:0]; end
            OP_LH, OP_LHU: begin ex_load = 1'b1; ex_be = 4'b0011 << ex_ea[1:0]; end
            OP_LW:    ex_load = 1'b1;
            OP_SB:    begin ex_store = 1'b1; ex_be = 4'b0001 << ex_ea[1:0]; ex_wdata = {4{rt_val[7:0]}}; end
            OP_SH:    begin ex_store = 1'b1; ex_be = 4'b0011 << ex_ea[1:0]; ex_wdata = {2{rt_val[15:0]}}; end
            OP_SW:    ex_store = 1'b1;
            default:  ;
        endcase
    end

    assign ld_half = 16'(readdata >> {ea_q[1:0], 3'b000});

    // Lane extraction for the load returning on readdata in ST_WB.
    always_comb begin
        case (ld_op_q)
            OP_LB:   ld_data = {{24{ld_half[7]}}, ld_half[7:0]};
            OP_LBU:  ld_data = {24'd0, ld_half[7:0]};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = readdata;
        endcase
    end

    // Single register write port shared by ALU results and load returns.
    always_comb begin
        rf_we = 1'b0;
        rf_wa = ex_wa;
        rf_wd = ex_wd;
        if (state_q == ST_EXEC) begin
            rf_we = ex_we;
        end else if (state_q == ST_WB) begin
            rf_we = 1'b1;
            rf_wa = ld_rt_q;
            rf_wd = ld_data;
        end
    end

    // Next-state, PC/delay-slot tracking and load/store context capture.
    // pc_q is the instruction being run, npc_q the one after it, so a taken
    // branch only redirects npc and the delay slot executes naturally.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        npc_d       = npc_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        ea_d        = ea_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        mem_store_d = mem_store_q;
        ld_op_d     = ld_op_q;
        ld_rt_d     = ld_rt_q;
        case (state_q)
            ST_FETCH: if (!waitrequest) state_d = ST_EXEC;
            ST_EXEC: begin
                pc_d        = npc_q;
                npc_d       = ex_take ? ex_target : npc_q + 32'd4;
                hi_d        = ex_hi;
                lo_d        = ex_lo;
                ea_d        = ex_ea;
                mem_be_d    = ex_be;
                mem_wdata_d = ex_wdata;
                mem_store_d = ex_store;
                ld_op_d     = op;
                ld_rt_d     = rt;
                if (ex_load || ex_store) state_d = ST_MEM;
                else if (npc_q == 32'd0)  state_d = ST_HALT;
                else                      state_d = ST_FETCH;
            end
            ST_MEM: begin
                if (!waitrequest) begin
                    if (!mem_store_q)        state_d = ST_WB;
                    else if (pc_q == 32'd0)  state_d = ST_HALT;
                    else                     state_d = ST_FETCH;
                end
            end
            ST_WB:   state_d = (pc_q == 32'd0) ? ST_HALT : ST_FETCH;
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    // Architectural and FSM state; reset aborts whatever is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_VECTOR;
            npc_q       <= RESET_VECTOR + 32'd4;
            hi_q        <= '0;
            lo_q        <= '0;
            ea_q        <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            mem_store_q <= 1'b0;
            ld_op_q     <= '0;
            ld_rt_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            npc_q       <= npc_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            ea_q        <= ea_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            mem_store_q <= mem_store_d;
            ld_op_q     <= ld_op_d;
            ld_rt_q     <= ld_rt_d;
        end
    end

    // Bus request outputs; reset forces the bus idle combinationally.
    always_comb begin
        read       = 1'b0;
        write      = 1'b0;
        address    = {pc_q[31:2], 2'b00};
        byteenable = 4'b0000;
        writedata  = mem_wdata_q;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    read       = 1'b1;
                    byteenable = 4'b1111;
                end
                ST_MEM: begin
                    address    = {ea_q[31:2], 2'b00};
                    byteenable = mem_be_q;
                    read       = !mem_store_q;
                    write      = mem_store_q;
                end
                default: ;
            endcase
        end
    end

    assign active = (state_q != ST_HALT);

endmodule

// File: tb/tb_mips_cpu_bus.sv
// Directed program bench for mips_cpu_bus: ROM at 0xBFC00000, small RAM at 0.
module tb_mips_cpu_bus;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset;
    logic        active;
    logic [31:0] register_v0;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata = 32'd0;

    logic [31:0] rom [0:127];
    logic [31:0] ram [0:63];
    logic [3:0]  rd_be_log [0:15];
    int          rd_cnt = 0;
    logic        wait_force = 1'b0;
    int          errors = 0;
    int          checks = 0;
    logic        found;

    assign waitrequest = wait_force;

    always #5 clk = ~clk;

    mips_cpu_bus #(.RESET_VECTOR(RV)) dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .register_v0 (register_v0),
        .address     (address),
        .write       (write),
        .read        (read),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    // Memory model: one-cycle read latency, byte-lane writes, RAM reloaded on reset.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'd0;
            ram[1] <= 32'h5C3AF8FC;
            ram[2] <= 32'h2EAC0652;
            rd_cnt <= 0;
        end else begin
            if (read && !waitrequest) begin
                if (address[31:28] == 4'hB) begin
                    readdata <= rom[address[8:2]];
                end else begin
                    readdata <= ram[address[7:2]];
                    if (rd_cnt < 16) rd_be_log[rd_cnt] <= byteenable;
                    rd_cnt <= rd_cnt + 1;
                end
            end
            if (write && !waitrequest && address[31:28] != 4'hB) begin
                for (int b = 0; b < 4; b++)
                    if (byteenable[b]) ram[address[7:2]][8*b +: 8] <= writedata[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] prog [0:66];
        prog = '{
            32'h8C010004, 32'h8C020008, 32'h00221821, 32'h00222023, // LW LW ADDU SUBU
            32'hAC030010, 32'hAC040014, 32'h0024001A, 32'h00002810, // SW SW DIV MFHI
            32'h00003012, 32'hAC050018, 32'hAC06001C, 32'h00600011, // MFLO SW SW MTHI
            32'h00800013, 32'h00003810, 32'h00004012, 32'hAC070020, // MTLO MFHI MFLO SW
            32'hAC080024, 32'h80050006, 32'h8406000A, 32'h00C50019, // SW LB LH MULTU
            32'h00004812, 32'h00005010, 32'hAC090028, 32'hAC0A002C, // MFLO MFHI SW SW
            32'h10210006, 32'h240B0055, 32'h240C0001, 32'h240C0001, // BEQ slot skip skip
            32'h240C0001, 32'h240C0001, 32'h240C0001, 32'hAC0B0030, // skip x3, SW
            32'hAC0C0034, 32'h1C600004, 32'h240D0007, 32'h25AD0001, // SW BGTZ ADDIU ADDIU
            32'hAC0D0038, 32'hA00B003D, 32'hA40D0042, 32'h900E0004, // SW SB SH LBU
            32'h800F0004, 32'h94100004, 32'h84110004, 32'hAC0E0044, // LB LHU LH SW
            32'hAC0F0048, 32'hAC10004C, 32'hAC110050, 32'h3C121234, // SW SW SW LUI
            32'h36528765, 32'h0064982A, 32'h0064A02B, 32'h0003A903, // ORI SLT SLTU SRA
            32'h2416FFFF, 32'h3077FFFF, 32'hAC120054, 32'hAC130058, // ADDIU ANDI SW SW
            32'hAC14005C, 32'hAC150060, 32'hAC160064, 32'hAC170068, // SW x4
            32'h0FF0003F, 32'h00201021, 32'h240C0001, 32'hAC1F006C, // JAL slot skip SW
            32'h00000008, 32'hAC020070, 32'hAC010074                // JR $0, slot, dead
        };
        for (int i = 0; i < 128; i++) rom[i] = 32'd0;
        for (int i = 0; i < 67; i++) rom[i] = prog[i];

        reset = 1'b1;
        wait_force = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_read", {31'd0, read}, 32'd0);
        check("rst_write", {31'd0, write}, 32'd0);
        check("rst_be", {28'd0, byteenable}, 32'd0);
        check("rst_active", {31'd0, active}, 32'd1);
        check("rst_v0", register_v0, 32'd0);

        // Stall the very first fetch for three cycles.
        wait_force = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_addr", address, RV);
            check("stall_read", {31'd0, read}, 32'd1);
            check("stall_write", {31'd0, write}, 32'd0);
        end
        wait_force = 1'b0;

        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (write && address == 32'h10) found = 1'b1;
        end
        check("store10_seen", {31'd0, found}, 32'd1);
        check("v0_after_lw", register_v0, 32'h2EAC0652);

        for (int i = 0; i < 5000 && active === 1'b1; i++) @(negedge clk);
        check("halt_active", {31'd0, active}, 32'd0);
        check("halt_read", {31'd0, read}, 32'd0);
        check("halt_write", {31'd0, write}, 32'd0);
        check("final_v0", register_v0, 32'h5C3AF8FC);
        check("addu", ram[4], 32'h8AE6FF4E);
        check("subu", ram[5], 32'h2D8EF2AA);
        check("div_hi", ram[6], 32'h011D13A8);
        check("div_lo", ram[7], 32'h00000002);
        check("mthi", ram[8], 32'h8AE6FF4E);
        check("mtlo", ram[9], 32'h2D8EF2AA);
        check("multu_lo", ram[10], 32'h000A92F8);
        check("multu_hi", ram[11], 32'h00000000);
        check("beq_slot", ram[12], 32'h00000055);
        check("beq_skip", ram[13], 32'h00000000);
        check("bgtz_fall", ram[14], 32'h00000008);
        check("sb_lane", ram[15], 32'h00005500);
        check("sh_lane", ram[16], 32'h00080000);
        check("lbu", ram[17], 32'h000000FC);
        check("lb_neg", ram[18], 32'hFFFFFFFC);
        check("lhu", ram[19], 32'h0000F8FC);
        check("lh_neg", ram[20], 32'hFFFFF8FC);
        check("lui_ori", ram[21], 32'h12348765);
        check("slt", ram[22], 32'h00000001);
        check("sltu", ram[23], 32'h00000000);
        check("sra", ram[24], 32'hF8AE6FF4);
        check("addiu_neg", ram[25], 32'hFFFFFFFF);
        check("andi_zext", ram[26], 32'h0000FF4E);
        check("jal_link", ram[27], 32'hBFC000F8);
        check("jr0_slot", ram[28], 32'h5C3AF8FC);
        check("after_halt", ram[29], 32'h00000000);
        check("be_lb6", {28'd0, rd_be_log[2]}, 32'h4);
        check("be_lh10", {28'd0, rd_be_log[3]}, 32'hC);
        check("be_lbu4", {28'd0, rd_be_log[4]}, 32'h1);
        check("be_lhu4", {28'd0, rd_be_log[6]}, 32'h3);

        repeat (5) @(negedge clk);
        check("halt_hold_active", {31'd0, active}, 32'd0);
        check("halt_hold_read", {31'd0, read}, 32'd0);

        // Reset in the middle of a stalled data read.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst2_active", {31'd0, active}, 32'd1);
        reset = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (read && address == 32'h4) found = 1'b1;
        end
        check("mem_read_seen", {31'd0, found}, 32'd1);
        check("mem_read_be", {28'd0, byteenable}, 32'hF);
        wait_force = 1'b1;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_read", {31'd0, read}, 32'd0);
        check("abort_write", {31'd0, write}, 32'd0);
        check("abort_be", {28'd0, byteenable}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        wait_force = 1'b0;
        reset = 1'b0;
        #1;
        check("refetch_addr", address, RV);
        check("refetch_read", {31'd0, read}, 32'd1);

        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (write && address == 32'h10) found = 1'b1;
        end
        check("rerun_store_seen", {31'd0, found}, 32'd1);
        check("rerun_v0", register_v0, 32'h2EAC0652);
        check("rerun_wdata", writedata, 32'h8AE6FF4E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
